// File: rtl/axi2amm_pkg.sv
// Shared types and constants for the AXI4-Lite to Avalon-MM bridge.
package axi2amm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StBresp,
    StRresp
  } state_e;

  typedef enum logic {
    GWr,
    GRd
  } grant_e;

  localparam logic [1:0] RespOkay = 2'b00;

endpackage

// File: rtl/axi2amm_hold.sv
// One-entry holding buffer for a single AXI request channel.
module axi2amm_hold #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] data,
  output logic             full,
  output logic             ready
);

  logic [Width-1:0] data_q;
  logic             full_q;

  // Load takes priority so a clear and a refill on the same edge keep the new entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      data_q <= din;
      full_q <= 1'b1;
    end else if (clear) begin
      full_q <= 1'b0;
    end
  end

  assign data  = data_q;
  assign full  = full_q;
  assign ready = ~full_q;

endmodule

// File: rtl/axi2amm.sv
// AXI4-Lite slave to Avalon-MM master bridge; one AMM transfer outstanding at a time.
module axi2amm
  import axi2amm_pkg::*;
#(
  parameter int unsigned P_ASIZE  = 32,
  parameter int unsigned P_DBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [P_ASIZE-1:0]    axi_awaddr,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [P_DBYTES*8-1:0] axi_wdata,
  input  logic [P_DBYTES-1:0]   axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [P_ASIZE-1:0]    axi_araddr,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [P_DBYTES*8-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [P_ASIZE-1:0]    amm_address,
  output logic [P_DBYTES*8-1:0] amm_writedata,
  output logic [P_DBYTES-1:0]   amm_byteenable,
  output logic                  amm_write,
  output logic                  amm_read,
  input  logic [P_DBYTES*8-1:0] amm_readdata,
  input  logic                  amm_waitrequest
);

  localparam int unsigned DataW = P_DBYTES * 8;
  localparam logic [P_ASIZE-1:0] AddrMask = ~(P_ASIZE'(P_DBYTES - 1));

  state_e state_q, state_d;
  grant_e last_grant_q;
  logic   grant_wr, grant_rd;

  logic [P_ASIZE-1:0]        aw_data, ar_data;
  logic [DataW+P_DBYTES-1:0] w_data;
  logic                      aw_full, w_full, ar_full;
  logic                      wr_elig, rd_elig;

  logic [P_ASIZE-1:0]  addr_q;
  logic [DataW-1:0]    wdata_q, rdata_q;
  logic [P_DBYTES-1:0] be_q;

  axi2amm_hold #(.Width(P_ASIZE)) u_aw_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (axi_awvalid && axi_awready),
    .clear   (grant_wr),
    .din     (axi_awaddr),
    .data    (aw_data),
    .full    (aw_full),
    .ready   (axi_awready)
  );

  axi2amm_hold #(.Width(DataW + P_DBYTES)) u_w_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (axi_wvalid && axi_wready),
    .clear   (grant_wr),
    .din     ({axi_wstrb, axi_wdata}),
    .data    (w_data),
    .full    (w_full),
    .ready   (axi_wready)
  );

  axi2amm_hold #(.Width(P_ASIZE)) u_ar_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (axi_arvalid && axi_arready),
    .clear   (grant_rd),
    .din     (axi_araddr),
    .data    (ar_data),
    .full    (ar_full),
    .ready   (axi_arready)
  );

  assign wr_elig = aw_full && w_full;
  assign rd_elig = ar_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // When both are eligible, the side not granted last time wins.
  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_elig && (!rd_elig || last_grant_q == GRd)) begin
          grant_wr = 1'b1;
          state_d  = StWr;
        end else if (rd_elig) begin
          grant_rd = 1'b1;
          state_d  = StRd;
        end
      end
      StWr:    if (!amm_waitrequest) state_d = StBresp;
      StRd:    if (!amm_waitrequest) state_d = StRresp;
      StBresp: if (axi_bready)       state_d = StIdle;
      StRresp: if (axi_rready)       state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reset value GRd makes the first contended grant go to the write side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRd;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
    end else begin
      if (grant_wr) begin
        last_grant_q <= GWr;
        addr_q       <= aw_data & AddrMask;
        wdata_q      <= w_data[DataW-1:0];
        be_q         <= w_data[DataW+P_DBYTES-1:DataW];
      end else if (grant_rd) begin
        last_grant_q <= GRd;
        addr_q       <= ar_data & AddrMask;
      end
      if (state_q == StRd && !amm_waitrequest) begin
        rdata_q <= amm_readdata;
      end
    end
  end

  always_comb begin
    amm_write      = (state_q == StWr);
    amm_read       = (state_q == StRd);
    axi_bvalid     = (state_q == StBresp);
    axi_rvalid     = (state_q == StRresp);
    axi_bresp      = RespOkay;
    axi_rresp      = RespOkay;
    amm_address    = addr_q;
    amm_writedata  = wdata_q;
    amm_byteenable = be_q;
    axi_rdata      = rdata_q;
  end

endmodule

// File: tb/tb_axi2amm.sv
// Directed self-checking bench for the axi2amm bridge.
module tb_axi2amm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b1;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b1;
  logic [31:0] amm_address;
  logic [31:0] amm_writedata;
  logic [3:0]  amm_byteenable;
  logic        amm_write;
  logic        amm_read;
  logic [31:0] amm_readdata = '0;
  logic        amm_waitrequest = 1'b0;

  int checks = 0;
  int failures = 0;

  axi2amm #(.P_ASIZE(32), .P_DBYTES(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .axi_awaddr      (axi_awaddr),
    .axi_awvalid     (axi_awvalid),
    .axi_awready     (axi_awready),
    .axi_wdata       (axi_wdata),
    .axi_wstrb       (axi_wstrb),
    .axi_wvalid      (axi_wvalid),
    .axi_wready      (axi_wready),
    .axi_bresp       (axi_bresp),
    .axi_bvalid      (axi_bvalid),
    .axi_bready      (axi_bready),
    .axi_araddr      (axi_araddr),
    .axi_arvalid     (axi_arvalid),
    .axi_arready     (axi_arready),
    .axi_rdata       (axi_rdata),
    .axi_rresp       (axi_rresp),
    .axi_rvalid      (axi_rvalid),
    .axi_rready      (axi_rready),
    .amm_address     (amm_address),
    .amm_writedata   (amm_writedata),
    .amm_byteenable  (amm_byteenable),
    .amm_write       (amm_write),
    .amm_read        (amm_read),
    .amm_readdata    (amm_readdata),
    .amm_waitrequest (amm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    axi_arvalid = 1'b0;
    axi_bready = 1'b1;
    axi_rready = 1'b1;
    amm_waitrequest = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(axi_awready && axi_wready && axi_arready && !amm_write && !amm_read &&
             !axi_bvalid && !axi_rvalid) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL drain_timeout: got busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready: got %b required 111", {axi_awready, axi_wready, axi_arready});
    end
    checks++;
    if ({axi_bvalid, axi_rvalid, axi_bresp, axi_rresp, amm_write, amm_read} !== 8'h00) begin
      failures++;
      $display("FAIL reset_strobes: got %b required 00000000",
               {axi_bvalid, axi_rvalid, axi_bresp, axi_rresp, amm_write, amm_read});
    end
    checks++;
    if ({amm_address, amm_writedata, amm_byteenable, axi_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_regs: got addr=%h wd=%h be=%h rd=%h required all zero",
               amm_address, amm_writedata, amm_byteenable, axi_rdata);
    end
  endtask

  task automatic test_single_write();
    axi_awaddr = 32'h0000_0104;
    axi_awvalid = 1'b1;
    axi_wdata = 32'hDEAD_BEEF;
    axi_wstrb = 4'hF;
    axi_wvalid = 1'b1;
    tick();  // edge T: both handshakes
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    checks++;
    if ({amm_write, axi_awready, axi_wready} !== 3'b000) begin
      failures++;
      $display("FAIL sw_t0: got write/awready/wready=%b required 000",
               {amm_write, axi_awready, axi_wready});
    end
    tick();  // T+1
    checks++;
    if (amm_write !== 1'b1 || amm_address !== 32'h104 || amm_writedata !== 32'hDEADBEEF ||
        amm_byteenable !== 4'hF || axi_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL sw_t1: got w=%b a=%h d=%h be=%h bv=%b required 1 104 deadbeef f 0",
               amm_write, amm_address, amm_writedata, amm_byteenable, axi_bvalid);
    end
    tick();  // T+2
    checks++;
    if (amm_write !== 1'b0 || axi_bvalid !== 1'b1 || axi_bresp !== 2'b00) begin
      failures++;
      $display("FAIL sw_t2: got w=%b bv=%b br=%b required 0 1 00",
               amm_write, axi_bvalid, axi_bresp);
    end
    tick();
    checks++;
    if ({axi_bvalid, amm_write} !== 2'b00) begin
      failures++;
      $display("FAIL sw_done: got bvalid/write=%b required 00", {axi_bvalid, amm_write});
    end
  endtask

  task automatic test_stalled_read();
    axi_araddr = 32'h0000_0203;
    axi_arvalid = 1'b1;
    amm_waitrequest = 1'b1;
    amm_readdata = 32'hBAD0_0000;
    tick();  // edge T
    axi_arvalid = 1'b0;
    checks++;
    if (amm_read !== 1'b0) begin
      failures++;
      $display("FAIL sr_t0: got amm_read=%b required 0", amm_read);
    end
    tick();  // T+1
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (amm_read !== 1'b1 || amm_address !== 32'h200 || axi_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL sr_hold%0d: got rd=%b a=%h rv=%b required 1 200 0",
                 i, amm_read, amm_address, axi_rvalid);
      end
      if (i == 3) begin
        amm_waitrequest = 1'b0;
        amm_readdata = 32'h1234_5678;
      end
      tick();
    end
    amm_readdata = 32'hBAD0_0001;
    checks++;
    if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h12345678 || amm_read !== 1'b0 ||
        axi_rresp !== 2'b00) begin
      failures++;
      $display("FAIL sr_t5: got rv=%b rd=%h amm_read=%b rr=%b required 1 12345678 0 00",
               axi_rvalid, axi_rdata, amm_read, axi_rresp);
    end
    tick();
    checks++;
    if (axi_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL sr_done: got rvalid=%b required 0", axi_rvalid);
    end
  endtask

  task automatic test_split_write();
    axi_wdata = 32'hCAFE_0001;
    axi_wstrb = 4'h3;
    axi_wvalid = 1'b1;
    axi_awaddr = 32'h0000_0042;
    tick();  // edge 0: W only
    axi_wvalid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) axi_awvalid = 1'b1;
      tick();
      axi_awvalid = 1'b0;
      checks++;
      if (axi_wready !== 1'b0 || amm_write !== 1'b0) begin
        failures++;
        $display("FAIL split_c%0d: got wready=%b write=%b required 0 0", i, axi_wready,
                 amm_write);
      end
    end
    tick();  // edge 5
    checks++;
    if (amm_write !== 1'b1 || amm_address !== 32'h40 || amm_writedata !== 32'hCAFE0001 ||
        amm_byteenable !== 4'h3) begin
      failures++;
      $display("FAIL split_c5: got w=%b a=%h d=%h be=%h required 1 40 cafe0001 3",
               amm_write, amm_address, amm_writedata, amm_byteenable);
    end
    drain();
  endtask

  task automatic test_alternate();
    logic grants[4];
    int   n;
    int   cyc;
    apply_reset();
    axi_awaddr = 32'h10;
    axi_wdata = 32'h5555_AAAA;
    axi_wstrb = 4'hF;
    axi_araddr = 32'h20;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    axi_arvalid = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (amm_write || amm_read) begin
        grants[n] = amm_read;  // 0 = write, 1 = read
        n++;
      end
    end
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    axi_arvalid = 1'b0;
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL alt_count: got %0d grants required 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (grants[i] !== logic'(i % 2)) begin
        failures++;
        $display("FAIL alt_grant%0d: got %s required %s", i, grants[i] ? "RD" : "WR",
                 (i % 2) ? "RD" : "WR");
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    axi_bready = 1'b0;
    axi_awaddr = 32'h100;
    axi_wdata = 32'h1111_1111;
    axi_wstrb = 4'hF;
    axi_awvalid = 1'b1;
    axi_wvalid = 1'b1;
    tick();  // edge T: first pair
    axi_awaddr = 32'h300;
    axi_wdata = 32'h2222_2222;
    tick();  // T+1: first write granted, buffers free
    checks++;
    if (amm_write !== 1'b1 || amm_address !== 32'h100) begin
      failures++;
      $display("FAIL bp_first: got w=%b a=%h required 1 100", amm_write, amm_address);
    end
    tick();  // T+2: second pair buffered
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (axi_bvalid !== 1'b1 || axi_awready !== 1'b0 || axi_wready !== 1'b0 ||
          amm_write !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d: got bv=%b awr=%b wr=%b w=%b required 1 0 0 0",
                 i, axi_bvalid, axi_awready, axi_wready, amm_write);
      end
      tick();
    end
    axi_bready = 1'b1;
    tick();
    checks++;
    if (axi_bvalid !== 1'b0 || amm_write !== 1'b0) begin
      failures++;
      $display("FAIL bp_bhs: got bv=%b w=%b required 0 0", axi_bvalid, amm_write);
    end
    tick();
    checks++;
    if (amm_write !== 1'b1 || amm_address !== 32'h300 || amm_writedata !== 32'h22222222) begin
      failures++;
      $display("FAIL bp_second: got w=%b a=%h d=%h required 1 300 22222222",
               amm_write, amm_address, amm_writedata);
    end
    drain();
  endtask

  task automatic test_reset_mid_read();
    axi_araddr = 32'h80;
    axi_arvalid = 1'b1;
    amm_waitrequest = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    axi_awaddr = 32'h84;
    axi_awvalid = 1'b1;  // lone AW, should be discarded by reset
    tick();
    axi_awvalid = 1'b0;
    checks++;
    if (amm_read !== 1'b1 || axi_awready !== 1'b0) begin
      failures++;
      $display("FAIL rst_pre: got rd=%b awr=%b required 1 0", amm_read, axi_awready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (amm_read !== 1'b0 || axi_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got rd=%b rv=%b required 0 0", amm_read, axi_rvalid);
    end
    tick();
    reset_n = 1'b1;
    amm_waitrequest = 1'b0;
    tick();
    tick();
    checks++;
    if ({axi_awready, axi_wready, axi_arready, amm_read, amm_write, axi_rvalid} !== 6'b111000)
    begin
      failures++;
      $display("FAIL rst_after: got %b required 111000",
               {axi_awready, axi_wready, axi_arready, amm_read, amm_write, axi_rvalid});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stalled_read();
    test_split_write();
    test_alternate();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi2amm.md
# axi2amm

AXI4-Lite slave to Avalon-MM master bridge, the inverse of the existing AMM-to-AXI bridge. It accepts AXI4-Lite reads and writes from an interconnect master and replays them, one at a time, as Avalon-MM transfers towards AMM peripherals that use waitrequest and zero-latency readdata. Each AXI channel has a one-entry holding buffer, so the next request can be accepted while the current AMM transfer is still in progress.

## Interface
- P_ASIZE, 32: address width in bits (byte addresses).
- P_DBYTES, 4: data bus width in bytes; a power of two.
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- axi_awaddr / axi_awvalid / axi_awready  in/in/out  P_ASIZE/1/1  write address channel.
- axi_wdata / axi_wstrb / axi_wvalid / axi_wready  in/in/in/out  P_DBYTES*8/P_DBYTES/1/1  write data channel.
- axi_bresp / axi_bvalid / axi_bready  out/out/in  2/1/1  write response channel.
- axi_araddr / axi_arvalid / axi_arready  in/in/out  P_ASIZE/1/1  read address channel.
- axi_rdata / axi_rresp / axi_rvalid / axi_rready  out/out/out/in  P_DBYTES*8/2/1/1  read data channel.
- amm_address  out  P_ASIZE  byte address; low log2(P_DBYTES) bits are forced to 0.
- amm_writedata / amm_byteenable  out  P_DBYTES*8/P_DBYTES  write data and byte enables (byteenable = wstrb).
- amm_write / amm_read  out  1/1  transfer strobes.
- amm_readdata  in  P_DBYTES*8  read data; valid in the cycle where amm_read=1 and amm_waitrequest=0.
- amm_waitrequest  in  1  slave stall.

## Operation
- There are three holding buffers (AW, W, AR), each with a full flag.
  - A buffer loads on valid&&ready.
  - Each ready output is the inverse of that buffer's full flag.
- The state machine has five states: IDLE, WR, RD, BRESP, RRESP.
- IDLE:
  - A write is eligible when both the AW and W buffers are full.
  - A read is eligible when the AR buffer is full.
  - If only one is eligible, it is granted.
  - If both are eligible, grant alternates using a last_grant flag; after reset, write wins.
  - On grant, the buffer contents are copied into the AMM output registers, the used buffers are cleared in the same edge, and the state moves to WR or RD.
- WR: amm_write=1. On !amm_waitrequest, go to BRESP.
- RD: amm_read=1. On !amm_waitrequest, capture amm_readdata into axi_rdata and go to RRESP.
- BRESP: bvalid=1, bresp=2'b00. On bready, go to IDLE.
- RRESP: rvalid=1, rresp=2'b00. On rready, go to IDLE.
- Responses are always OKAY; no error path exists.
- Only one AMM transfer is outstanding at a time. The buffers keep accepting new requests during WR, RD, BRESP and RRESP.
- A buffer cleared at grant may reload in the same edge if its valid&&ready is also true. Ready is sampled before the edge, so no conflict arises.
- AW and W can arrive in either order or in the same cycle. A lone AW or a lone W waits indefinitely.

## Timing
- Reset values:
  - awready=wready=arready=1 (buffers empty).
  - bvalid=rvalid=0, bresp=rresp=0, rdata=0.
  - amm_write=amm_read=0, amm_address/writedata/byteenable=0.
  - State is IDLE and last_grant selects write.
- Asserting reset mid-transfer immediately drops amm_write/amm_read and bvalid/rvalid, and discards the buffer contents.
- Write latency: AW and W handshaken at cycle T → amm_write=1 at T+1. With waitrequest=0, bvalid=1 at T+2.
- Read latency: AR handshaken at T → amm_read=1 at T+1. With waitrequest=0, rvalid=1 at T+2, carrying readdata from T+1.
- Each waitrequest=1 cycle adds one cycle. AMM outputs are stable while waitrequest=1.
- Peak throughput is one transaction per 3 cycles (IDLE→WR/RD→BRESP/RRESP).
- All outputs come from registers or from flag inversions; there is no input-to-output combinational path.

## Structure
- axi2amm_pkg contains:
  - the state enum (IDLE, WR, RD, BRESP, RRESP);
  - the constant RESP_OKAY=2'b00;
  - the grant-type enum (G_WR, G_RD).
- Sub-module axi2amm_hold is a parameterized-width one-entry buffer (data, full, ready, load, clear). It is instantiated three times (AW, W, AR).

## Test plan
- Single write: AW=0x0000_0104, W=0xDEAD_BEEF, wstrb=4'hF in the same cycle, waitrequest=0 → amm_write is one cycle with address 0x104 and writedata 0xDEADBEEF; bvalid at T+2, bresp=0.
- Stalled read: AR=0x0000_0203, waitrequest=1 for 3 cycles, readdata=0x1234_5678 → amm_address=0x200; amm_read held for 4 cycles; rdata=0x12345678; rvalid at T+5.
- Split write: W at cycle 0, AW at cycle 4 → no amm_write before cycle 5; wready=0 during cycles 1–4.
- Simultaneous read and write eligible, repeated 4 times → grants alternate WR, RD, WR, RD. The first grant is WR after reset.
- Backpressure: bready=0 for 5 cycles while a second AW/W pair arrives → the second pair is buffered, awready=wready=0, and the second amm_write starts only after the first B handshake.
- Reset asserted during RD with waitrequest=1 → amm_read=0 and rvalid=0 asynchronously; all readies=1 after release.
